bcd_display_mux: RTL
====================

// Module: bcd_display_mux
// PURPOSE
//  Consumes the two-digit BCD count (BCD1 tens, BCD0 units) and drives a
//  time-multiplexed 2-digit 7-segment display (active-low segments/anodes).
//  Snapshots both digits once per frame so a display never tears mid-count.
//  Adds an anti-ghosting guard interval and shows '-' for codes 10..15.
// PARAMETERS
//  REFRESH_DIV  50000  clock cycles per digit slot (>= GUARD+1, >= 2)
//  GUARD        2      cycles at start of each slot with anodes off (>= 1)
//  DIV_W        16     prescaler width; 2**DIV_W >= REFRESH_DIV
// PORTS
//  Clock  in   1      single clock; all state updates on posedge
//  Clear  in   1      synchronous, active-high reset
//  BCD1   in   4      tens digit from counter
//  BCD0   in   4      units digit from counter
//  Seg    out  7      {g,f,e,d,c,b,a}, active-low (0 = lit)
//  An     out  2      digit enables, active-low; An[1]=tens, An[0]=units
//  Frame  out  1      1-cycle pulse, cycle after each snapshot
// BEHAVIOUR
//  - State: prescaler cnt (0..REFRESH_DIV-1), slot (D0 units / D1 tens),
//    shadow regs sh1/sh0. All outputs registered.
//  - Clear=1 at an edge: cnt=0, slot=D0, sh1=sh0=0, An=2'b11, Seg=7'h7F,
//    Frame=0. Clear mid-frame aborts the frame; no partial state survives.
//  - Each edge with Clear=0:
//    cnt <= (cnt==REFRESH_DIV-1) ? 0 : cnt+1; slot toggles on that wrap.
//    if (cnt==0 && slot==D0): sh1<=BCD1, sh0<=BCD0, Frame<=1; else Frame<=0.
//    if (cnt<GUARD): An<=2'b11, Seg<=7'h7F (guard; covers snapshot edge).
//    else An<=(slot==D0)?2'b10:2'b01; Seg<=dec(slot==D0?sh0:sh1).
//  - First edge after Clear deasserts is a snapshot edge (cnt=0, D0).
//  - Latency: An/Seg reflect (cnt,slot) of the previous cycle; 1 cycle.
//  - Frame period = 2*REFRESH_DIV cycles; inputs outside the snapshot edge
//    are ignored (BCD changes mid-frame appear next frame).
//  - dec(): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex);
//    10..15 -> 7'h3F ('-', only g lit).
//  - Exactly one anode low at any time, never both; both high in guard.
// CONFIGURATION
//  BCD_DISP_LZB_EN defined: leading-zero blanking; in a D1 active interval
//    with sh1==0, Seg<=7'h7F (An still 2'b01). Units digit never blanked.
//  Not defined: tens digit 0 shown as '0' (7'h40).
// TESTING (REFRESH_DIV=8, GUARD=2)
//  1 Clear=1 for 3 cycles -> An=2'b11, Seg=7'h7F, Frame=0 throughout.
//  2 BCD1=4,BCD0=2, release Clear -> Frame=1 on 2nd cycle then every 16;
//    An=2'b10/Seg=7'h24 for 6 cycles, guard 2, An=2'b01/Seg=7'h19 6 cycles.
//  3 Change BCD0 2->7 at cnt=3 of D0 -> Seg stays 7'h24 this frame;
//    7'h78 shown from next frame's D0 active interval.
//  4 BCD0=4'hB -> units slot Seg=7'h3F; BCD0=9 -> 7'h10.
//  5 BCD1=0,BCD0=5 -> tens slot Seg=7'h7F with BCD_DISP_LZB_EN,
//    7'h40 without; units Seg=7'h12 both builds.
//  6 Clear=1 mid D1 slot -> next cycle reset values; after release
//    sequence restarts exactly as scenario 2.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver with per-frame digit snapshot and anti-ghost guard.
// Optional leading-zero blanking of the tens digit: define BCD_DISP_LZB_EN.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int DIV_W       = 16
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       Frame
);

  typedef enum logic {D0 = 1'b0, D1 = 1'b1} slot_t;

  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_C = DIV_W'(GUARD);

  logic [DIV_W-1:0] cnt;
  slot_t            slot;
  logic [3:0]       sh1, sh0;
  logic [3:0]       digit;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F;  // non-BCD codes show '-'
    endcase
  endfunction

  always_comb begin
    digit   = (slot == D0) ? sh0 : sh1;
    seg_nxt = dec(digit);
`ifdef BCD_DISP_LZB_EN
    if (slot == D1 && sh1 == 4'd0) seg_nxt = 7'h7F;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      cnt   <= '0;
      slot  <= D0;
      sh1   <= 4'd0;
      sh0   <= 4'd0;
      An    <= 2'b11;
      Seg   <= 7'h7F;
      Frame <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt  <= '0;
        slot <= (slot == D0) ? D1 : D0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Snapshot both digits at frame start so the display never tears.
      if (cnt == '0 && slot == D0) begin
        sh1   <= BCD1;
        sh0   <= BCD0;
        Frame <= 1'b1;
      end else begin
        Frame <= 1'b0;
      end
      // Guard interval blanks anodes; it also hides the snapshot edge.
      if (cnt < GUARD_C) begin
        An  <= 2'b11;
        Seg <= 7'h7F;
      end else begin
        An  <= (slot == D0) ? 2'b10 : 2'b01;
        Seg <= seg_nxt;
      end
    end
  end

endmodule
